// File: rtl/debounce_pkg.sv
// Shared constants for the debounce bank.
//   DEF_N_CH        default number of channels
//   DEF_CNT_W       default stability counter / threshold width
//   DEF_SYNC_STAGES default synchroniser depth
//   MIN_THRESH      smallest effective threshold; a programmed 0 is raised to this
package debounce_pkg;

  localparam int unsigned DEF_N_CH        = 4;
  localparam int unsigned DEF_CNT_W       = 20;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned MIN_THRESH      = 1;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, stability counter, clean level and
// registered rise/fall pulses.
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   i_bouncy     raw asynchronous input
//   i_thresh_eff effective threshold, always >= 1
//   i_en         count enable; low freezes counter and clean level
//   o_clean      debounced level (registered)
//   o_rise       one-cycle pulse in the first cycle o_clean shows 1
//   o_fall       one-cycle pulse in the first cycle o_clean shows 0
//   o_commit     high in the cycle before o_clean changes (feeds the bank's OR)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_bouncy,
  input  logic [CNT_W-1:0] i_thresh_eff,
  input  logic             i_en,
  output logic             o_clean,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_commit
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_clean;
  logic                   r_rise;
  logic                   r_fall;

  logic w_sync;
  logic w_mismatch;
  logic w_limit;
  logic w_commit;

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_mismatch = w_sync ^ r_clean;
  // >= rather than == so a threshold lowered below the running count commits
  // on the next mismatching cycle instead of counting up to a wrap.
  assign w_limit    = (r_cnt >= (i_thresh_eff - CNT_W'(1)));
  assign w_commit   = i_en & w_mismatch & w_limit;

  // Synchroniser keeps shifting even while i_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_bouncy};
    end
  end

  // Counter restarts on any agreeing cycle and on commit; it only increments
  // while below the limit, so it can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (!w_mismatch || w_limit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clean <= RESET_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_commit & w_sync;
      r_fall <= w_commit & ~w_sync;
      if (w_commit) begin
        r_clean <= w_sync;
      end
    end
  end

  assign o_clean  = r_clean;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_commit = w_commit;

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH independent debounce channels sharing one runtime threshold and
// enable, plus a combined change pulse.
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   bouncy_in   [N_CH]  raw asynchronous inputs
//   thresh      [CNT_W] stable-cycle count, 0 behaves as 1, quasi-static
//   en          count enable; low freezes debounce state
//   clean_out   [N_CH]  debounced levels (registered)
//   rise        [N_CH]  one-cycle pulse when a clean bit goes 0->1
//   fall        [N_CH]  one-cycle pulse when a clean bit goes 1->0
//   any_change  one-cycle pulse when any clean bit changes
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  bouncy_in,
  input  logic [CNT_W-1:0] thresh,
  input  logic             en,
  output logic [N_CH-1:0]  clean_out,
  output logic [N_CH-1:0]  rise,
  output logic [N_CH-1:0]  fall,
  output logic             any_change
);

  logic [CNT_W-1:0] w_thresh_eff;
  logic [N_CH-1:0]  w_commit;
  logic             r_any_change;

  // Clamp once here so every channel sees a threshold of at least 1.
  assign w_thresh_eff = (thresh < CNT_W'(MIN_THRESH)) ? CNT_W'(MIN_THRESH) : thresh;

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    debounce_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (RESET_VAL)
    ) u_channel (
      .clk          (clk),
      .rst          (rst),
      .i_bouncy     (bouncy_in[g]),
      .i_thresh_eff (w_thresh_eff),
      .i_en         (en),
      .o_clean      (clean_out[g]),
      .o_rise       (rise[g]),
      .o_fall       (fall[g]),
      .o_commit     (w_commit[g])
    );
  end

  // Registered alongside the channel pulses so it lines up with them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_any_change <= 1'b0;
    end else begin
      r_any_change <= |w_commit;
    end
  end

  assign any_change = r_any_change;

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

  localparam int   N  = 4;
  localparam int   CW = 20;
  localparam int   S  = 2;
  localparam logic RV = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  bouncy = '1;
  logic [CW-1:0] thresh = CW'(4);
  logic          en = 1'b1;
  logic [N-1:0]  clean_out, rise, fall;
  logic          any_change;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  debounce_bank #(
    .N_CH        (N),
    .CNT_W       (CW),
    .SYNC_STAGES (S),
    .RESET_VAL   (RV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bouncy_in  (bouncy),
    .thresh     (thresh),
    .en         (en),
    .clean_out  (clean_out),
    .rise       (rise),
    .fall       (fall),
    .any_change (any_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the synchronised view of the inputs is the input
  // sampled S edges earlier; a channel adopts the new level once it has been
  // seen for max(thresh,1) consecutive enabled mismatching cycles.
  logic [N-1:0] q_in[$];
  logic [N-1:0] m_sync;
  logic [N-1:0] m_clean = '0;
  logic [N-1:0] m_rise = '0;
  logic [N-1:0] m_fall = '0;
  logic         m_any = 1'b0;
  int           m_streak[N];
  int           teff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_in.delete();
      m_clean = {N{RV}};
      m_rise  = '0;
      m_fall  = '0;
      m_any   = 1'b0;
      for (int c = 0; c < N; c++) m_streak[c] = 0;
    end else begin
      m_sync = (q_in.size() >= S) ? q_in[S-1] : {N{RV}};
      teff   = (thresh == 0) ? 1 : int'(thresh);
      m_rise = '0;
      m_fall = '0;
      if (en) begin
        for (int c = 0; c < N; c++) begin
          if (m_sync[c] != m_clean[c]) begin
            if (m_streak[c] + 1 >= teff) begin
              m_clean[c] = m_sync[c];
              m_rise[c]  = m_sync[c];
              m_fall[c]  = ~m_sync[c];
              m_streak[c] = 0;
            end else begin
              m_streak[c]++;
            end
          end else begin
            m_streak[c] = 0;
          end
        end
      end
      m_any = |(m_rise | m_fall);
      q_in.push_front(bouncy);
      if (q_in.size() > S) void'(q_in.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model clean_out", 32'(clean_out), 32'(m_clean));
      check("model rise", 32'(rise), 32'(m_rise));
      check("model fall", 32'(fall), 32'(m_fall));
      check("model any_change", 32'(any_change), 32'(m_any));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic seen;

  initial begin
    #2 rst = 1'b1;
    chk_en = 1;
    // Reset with all inputs high
    cyc(2);
    check("reset clean_out", 32'(clean_out), 32'h0);
    check("reset rise", 32'(rise), 32'h0);
    check("reset any_change", 32'(any_change), 32'h0);
    rst = 1'b0;
    cyc(1);
    check("release c1 any", 32'(any_change), 32'h0);
    check("release c1 rise", 32'(rise), 32'h0);
    cyc(1);
    check("release c2 any", 32'(any_change), 32'h0);
    check("release c2 rise", 32'(rise), 32'h0);
    bouncy = 4'b0000;
    cyc(12);

    // Step on ch0, thresh=4: commits on the 6th edge
    bouncy = 4'b0001;
    cyc(5);
    check("step before", 32'(clean_out), 32'h0);
    cyc(1);
    check("step clean", 32'(clean_out), 32'h1);
    check("step rise", 32'(rise), 32'h1);
    check("step any", 32'(any_change), 32'h1);
    cyc(1);
    check("step rise gone", 32'(rise), 32'h0);
    check("step any gone", 32'(any_change), 32'h0);

    // Bounce on ch1: 3 high / 1 low never qualifies
    seen = 1'b0;
    for (int r = 0; r < 50; r++) begin
      for (int k = 0; k < 4; k++) begin
        bouncy[1] = (k < 3);
        cyc(1);
        seen |= rise[1] | fall[1] | clean_out[1];
      end
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      seen |= rise[1] | fall[1] | clean_out[1];
    end
    check("bounce activity", 32'(seen), 32'h0);
    check("bounce clean", 32'(clean_out), 32'h1);

    // Simultaneous rise ch1 / fall ch2
    bouncy = 4'b0100;
    cyc(10);
    check("simul setup", 32'(clean_out), 32'h4);
    bouncy = 4'b0010;
    cyc(5);
    check("simul before", 32'(clean_out), 32'h4);
    cyc(1);
    check("simul rise", 32'(rise), 32'h2);
    check("simul fall", 32'(fall), 32'h4);
    check("simul any", 32'(any_change), 32'h1);
    check("simul clean", 32'(clean_out), 32'h2);
    cyc(1);
    check("simul any single", 32'(any_change), 32'h0);

    // Freeze: 2 counted cycles, 10 frozen, then 2 more to commit
    bouncy = 4'b1010;
    cyc(4);
    en = 1'b0;
    cyc(10);
    check("freeze hold", 32'(clean_out), 32'h2);
    en = 1'b1;
    cyc(1);
    check("freeze 1 more", 32'(clean_out), 32'h2);
    cyc(1);
    check("freeze commit", 32'(clean_out), 32'hA);
    check("freeze rise", 32'(rise), 32'h8);

    // Threshold lowered 100 -> 3 at count 5
    thresh = CW'(100);
    bouncy = 4'b0010;
    cyc(7);
    check("lower before", 32'(clean_out), 32'hA);
    thresh = CW'(3);
    cyc(1);
    check("lower commit", 32'(clean_out), 32'h2);
    check("lower fall", 32'(fall), 32'h8);

    // Threshold 0 behaves as 1
    thresh = '0;
    bouncy = 4'b0011;
    cyc(2);
    check("t0 before", 32'(clean_out), 32'h2);
    cyc(1);
    check("t0 commit", 32'(clean_out), 32'h3);
    check("t0 rise", 32'(rise), 32'h1);

    // Reset mid-qualification discards the partial count
    thresh = CW'(4);
    bouncy = 4'b0000;
    cyc(10);
    check("rstmid setup", 32'(clean_out), 32'h0);
    bouncy = 4'b0001;
    cyc(5);
    #2 rst = 1'b1;
    cyc(1);
    check("rstmid in reset", 32'(clean_out), 32'h0);
    check("rstmid rise", 32'(rise), 32'h0);
    rst = 1'b0;
    cyc(5);
    check("rstmid before", 32'(clean_out), 32'h0);
    cyc(1);
    check("rstmid commit", 32'(clean_out), 32'h1);
    check("rstmid rise pulse", 32'(rise), 32'h1);
    cyc(2);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
